// File: rtl/nibble_serial_adder_pkg.sv
// Shared definitions for the nibble-serial adder.
//   NIBBLE_W  : width of the single carry-lookahead slice
//   state_t   : controller states IDLE/RUN/DONE (encodings 0/1/2)
//   cnt_width : width of the nibble counter, clog2(nib) with a 1-bit minimum
package nibble_serial_adder_pkg;

  localparam int unsigned NIBBLE_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  function automatic int unsigned cnt_width(input int unsigned nib);
    return (nib > 1) ? $clog2(nib) : 1;
  endfunction

endpackage

// File: rtl/nibble_serial_adder_cla4_slice.sv
// cla4_slice: combinational 4-bit carry-lookahead adder slice.
// Ports:
//   a, b [3:0] : operand nibbles
//   ci         : carry in
//   s  [3:0]   : sum nibble
//   co         : carry out of bit 3
//   c3         : carry into bit 3 (only with OVERFLOW_FLAG_EN, used for signed overflow)
// Every internal carry is a flat generate/propagate sum of products of the inputs,
// so no carry depends on a previous carry.
module cla4_slice
  import nibble_serial_adder_pkg::*;
(
  input  logic [NIBBLE_W-1:0] a,
  input  logic [NIBBLE_W-1:0] b,
  input  logic                ci,
  output logic [NIBBLE_W-1:0] s,
  output logic                co
`ifdef OVERFLOW_FLAG_EN
  ,
  output logic                c3
`endif
);

  logic [NIBBLE_W-1:0] g;
  logic [NIBBLE_W-1:0] p;
  logic [NIBBLE_W:0]   c;

  always_comb begin
    g = a & b;
    p = a ^ b;

    c[0] = ci;
    c[1] = g[0] | (p[0] & ci);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
         | (p[2] & p[1] & p[0] & ci);
    c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
         | (p[3] & p[2] & p[1] & g[0]) | (p[3] & p[2] & p[1] & p[0] & ci);

    s  = p ^ c[NIBBLE_W-1:0];
    co = c[4];
  end

`ifdef OVERFLOW_FLAG_EN
  assign c3 = c[3];
`endif

endmodule

// File: rtl/nibble_serial_adder.sv
// nibble_serial_adder: WIDTH-bit adder that processes one nibble per clock through a
// single cla4_slice, holding the inter-nibble carry in a register.
// Optional feature macro: OVERFLOW_FLAG_EN (adds the ovf output).
// Ports:
//   clk, rst            : clock, asynchronous active-high reset
//   in_valid/in_ready   : operand handshake (in_ready high only in IDLE)
//   a, b, cin           : operands, captured on the accept edge
//   out_valid/out_ready : result handshake (out_valid high only in DONE)
//   sum, cout           : registered result, held until the next result completes
//   busy                : high in RUN or DONE
//   ovf                 : signed overflow, valid with out_valid (OVERFLOW_FLAG_EN only)
module nibble_serial_adder
  import nibble_serial_adder_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy
`ifdef OVERFLOW_FLAG_EN
  ,
  output logic             ovf
`endif
);

  localparam int unsigned NIB   = WIDTH / NIBBLE_W;
  localparam int unsigned CNT_W = cnt_width(NIB);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NIB - 1);

  state_t               state;
  logic [WIDTH-1:0]     a_sh;
  logic [WIDTH-1:0]     b_sh;
  logic [WIDTH-1:0]     sum_sh;
  logic                 carry;
  logic [CNT_W-1:0]     cnt;

  logic [NIBBLE_W-1:0]  nib_s;
  logic                 nib_co;
  logic [WIDTH-1:0]     sum_next;
`ifdef OVERFLOW_FLAG_EN
  logic                 nib_c3;
`endif

  cla4_slice u_cla (
    .a  (a_sh[NIBBLE_W-1:0]),
    .b  (b_sh[NIBBLE_W-1:0]),
    .ci (carry),
    .s  (nib_s),
    .co (nib_co)
`ifdef OVERFLOW_FLAG_EN
    ,
    .c3 (nib_c3)
`endif
  );

  // New nibble enters at the top of the sum shift register. Expressed as shift/OR
  // rather than a concatenation so WIDTH=4 (no lower part to keep) still elaborates.
  always_comb begin
    sum_next = (sum_sh >> NIBBLE_W) | (WIDTH'(nib_s) << (WIDTH - NIBBLE_W));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      sum       <= '0;
      cout      <= 1'b0;
      a_sh      <= '0;
      b_sh      <= '0;
      sum_sh    <= '0;
      carry     <= 1'b0;
      cnt       <= '0;
`ifdef OVERFLOW_FLAG_EN
      ovf       <= 1'b0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            a_sh     <= a;
            b_sh     <= b;
            carry    <= cin;
            cnt      <= '0;
            state    <= ST_RUN;
            in_ready <= 1'b0;
            busy     <= 1'b1;
          end
        end

        ST_RUN: begin
          sum_sh <= sum_next;
          a_sh   <= a_sh >> NIBBLE_W;
          b_sh   <= b_sh >> NIBBLE_W;
          carry  <= nib_co;
          cnt    <= cnt + 1'b1;
          if (cnt == CNT_LAST) begin
            // Result registers load on the final nibble so they change only here
            // and keep their value through IDLE and the next RUN.
            state     <= ST_DONE;
            out_valid <= 1'b1;
            sum       <= sum_next;
            cout      <= nib_co;
`ifdef OVERFLOW_FLAG_EN
            ovf       <= nib_c3 ^ nib_co;
`endif
          end
        end

        ST_DONE: begin
          if (out_ready) begin
            state     <= ST_IDLE;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            in_ready  <= 1'b1;
          end
        end

        default: begin
          state     <= ST_IDLE;
          out_valid <= 1'b0;
          busy      <= 1'b0;
          in_ready  <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_nibble_serial_adder.sv
module tb_nibble_serial_adder;

  localparam int W    = 16;
  localparam int NIBS = W / 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // 16-bit instance
  logic          rst = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [W-1:0]  a = '0;
  logic [W-1:0]  b = '0;
  logic          cin = 1'b0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [W-1:0]  sum;
  logic          cout;
  logic          busy;
`ifdef OVERFLOW_FLAG_EN
  logic          ovf;
`endif

  // 4-bit instance (single-nibble corner case)
  logic          rst4 = 1'b0;
  logic          in_valid4 = 1'b0;
  logic          in_ready4;
  logic [3:0]    a4 = '0;
  logic [3:0]    b4 = '0;
  logic          cin4 = 1'b0;
  logic          out_valid4;
  logic          out_ready4 = 1'b0;
  logic [3:0]    sum4;
  logic          cout4;
  logic          busy4;
`ifdef OVERFLOW_FLAG_EN
  logic          ovf4;
`endif

  nibble_serial_adder #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .busy(busy)
`ifdef OVERFLOW_FLAG_EN
    , .ovf(ovf)
`endif
  );

  nibble_serial_adder #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst4), .in_valid(in_valid4), .in_ready(in_ready4),
    .a(a4), .b(b4), .cin(cin4), .out_valid(out_valid4), .out_ready(out_ready4),
    .sum(sum4), .cout(cout4), .busy(busy4)
`ifdef OVERFLOW_FLAG_EN
    , .ovf(ovf4)
`endif
  );

  int     checks = 0;
  int     errors = 0;
  longint cyc = 0;
  bit     hold_low = 1'b0;

  always @(posedge clk) cyc++;

  // Consumer readiness changes just after the rising edge so it is stable at negedge.
  always @(posedge clk) begin
    #1;
    out_ready  = hold_low ? 1'b0 : ($urandom_range(0, 3) != 0);
    out_ready4 = ($urandom_range(0, 2) != 0);
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic [W-1:0] s;
    logic         c;
    logic         v;
    longint       acc;
  } exp_t;

  typedef struct {
    logic [3:0] s;
    logic       c;
    logic       v;
    longint     acc;
  } exp4_t;

  exp_t  q[$];
  exp4_t q4[$];

  // Reference: plain integer addition; signed overflow from operand/result signs.
  function automatic exp_t model16(input logic [W-1:0] x, input logic [W-1:0] y,
                                   input logic ci, input longint acc);
    exp_t e;
    logic [31:0] t;
    t = 32'(x) + 32'(y) + 32'(ci);
    e.s = t[W-1:0];
    e.c = t[W];
    e.v = (x[W-1] == y[W-1]) && (e.s[W-1] != x[W-1]);
    e.acc = acc;
    return e;
  endfunction

  function automatic exp4_t model4(input logic [3:0] x, input logic [3:0] y,
                                   input logic ci, input longint acc);
    exp4_t e;
    int t;
    t = int'(x) + int'(y) + int'(ci);
    e.s = t[3:0];
    e.c = t[4];
    e.v = (x[3] == y[3]) && (e.s[3] != x[3]);
    e.acc = acc;
    return e;
  endfunction

  // Called at a negedge; returns at a negedge after the accept edge.
  task automatic send16(input logic [W-1:0] x, input logic [W-1:0] y, input logic ci);
    int n = 0;
    in_valid = 1'b1; a = x; b = y; cin = ci;
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      chk("accept_timeout16", in_ready, 1);
      in_valid = 1'b0;
    end else begin
      q.push_back(model16(x, y, ci, cyc + 1));
      @(negedge clk);
      in_valid = 1'b0;
    end
  endtask

  task automatic send4(input logic [3:0] x, input logic [3:0] y, input logic ci);
    int n = 0;
    in_valid4 = 1'b1; a4 = x; b4 = y; cin4 = ci;
    while (!in_ready4 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready4) begin
      chk("accept_timeout4", in_ready4, 1);
      in_valid4 = 1'b0;
    end else begin
      q4.push_back(model4(x, y, ci, cyc + 1));
      @(negedge clk);
      in_valid4 = 1'b0;
    end
  endtask

  // Monitor for the 16-bit instance: compares every cycle a result is presented,
  // which also covers stability under backpressure.
  bit seen = 1'b0;
  bit hs   = 1'b0;
  always @(negedge clk) begin
    if (rst) begin
      seen = 1'b0;
      hs   = 1'b0;
    end else begin
      if (hs) begin
        chk("reaccept_ready", in_ready, 1);
        chk("valid_drop", out_valid, 0);
        hs = 1'b0;
      end
      if (out_valid) begin
        if (q.size() == 0) begin
          chk("extra_result", out_valid, 0);
        end else begin
          if (!seen) chk("latency", cyc - q[0].acc, NIBS);
          seen = 1'b1;
          chk("sum", sum, q[0].s);
          chk("cout", cout, q[0].c);
`ifdef OVERFLOW_FLAG_EN
          chk("ovf", ovf, q[0].v);
`endif
          chk("busy_done", busy, 1);
          chk("in_ready_done", in_ready, 0);
          if (out_ready) begin
            void'(q.pop_front());
            seen = 1'b0;
            hs   = 1'b1;
          end
        end
      end
    end
  end

  bit seen4 = 1'b0;
  always @(negedge clk) begin
    if (!rst4 && out_valid4) begin
      if (q4.size() == 0) begin
        chk("extra_result4", out_valid4, 0);
      end else begin
        if (!seen4) chk("latency4", cyc - q4[0].acc, 1);
        seen4 = 1'b1;
        chk("sum4", sum4, q4[0].s);
        chk("cout4", cout4, q4[0].c);
`ifdef OVERFLOW_FLAG_EN
        chk("ovf4", ovf4, q4[0].v);
`endif
        if (out_ready4) begin
          void'(q4.pop_front());
          seen4 = 1'b0;
        end
      end
    end
  end

  task automatic drain;
    int n = 0;
    while ((q.size() != 0 || q4.size() != 0 || out_valid || out_valid4) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk("drain_q16", q.size(), 0);
    chk("drain_q4", q4.size(), 0);
  endtask

  initial begin
    int n;
    #2;
    rst = 1'b1; rst4 = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_sum", sum, 0);
    chk("rst_cout", cout, 0);
`ifdef OVERFLOW_FLAG_EN
    chk("rst_ovf", ovf, 0);
`endif
    chk("rst_in_ready4", in_ready4, 1);
    @(negedge clk);
    rst = 1'b0; rst4 = 1'b0;
    @(negedge clk);

    // Directed cases
    send16(16'h0000, 16'h0000, 1'b0);
    send16(16'hFFFF, 16'h0001, 1'b0);
    send16(16'h1234, 16'h4321, 1'b1);
    send16(16'h7FFF, 16'h0001, 1'b0);
    send16(16'h8000, 16'h8000, 1'b0);
    send16(16'hFFFF, 16'hFFFF, 1'b1);
    drain();

    // Backpressure: result must hold, extra in_valid must be ignored
    hold_low = 1'b1;
    @(negedge clk);
    @(negedge clk);
    send16(16'hA5A5, 16'h5A5B, 1'b1);
    n = 0;
    while (!out_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("bp_out_valid", out_valid, 1);
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; a = W'($urandom); b = W'($urandom); cin = 1'b0;
      chk("bp_in_ready", in_ready, 0);
      @(negedge clk);
    end
    in_valid = 1'b0;
    hold_low = 1'b0;
    drain();

    // Random traffic
    for (int i = 0; i < 60; i++) begin
      send16(W'($urandom), W'($urandom), 1'(($urandom)));
      if ($urandom_range(0, 3) == 0) @(negedge clk);
    end
    drain();

    // Reset in the second RUN cycle discards the operation
    n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    in_valid = 1'b1; a = 16'h1111; b = 16'h2222; cin = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    chk("mid_run_busy", busy, 1);
    rst = 1'b1;
    #1;
    chk("abort_out_valid", out_valid, 0);
    chk("abort_busy", busy, 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("post_rst_in_ready", in_ready, 1);
    chk("post_rst_sum", sum, 0);
    chk("post_rst_cout", cout, 0);
    repeat (NIBS + 2) @(negedge clk);
    chk("no_result_after_abort", out_valid, 0);

    // Exhaustive WIDTH=4 sweep
    for (int i = 0; i < 512; i++) begin
      send4(i[3:0], i[7:4], i[8]);
    end
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
